// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux and
// ALU selects, data-processing cmd codes and ARM condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
               (cmd == CMD_CMP) || (cmd == CMD_ORR);
    endfunction

    function automatic logic cmd_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

    // CMP only sets flags; unsupported commands must leave the register file alone.
    function automatic logic cmd_writes(input logic [3:0] cmd);
        return cmd_supported(cmd) && (cmd != CMD_CMP);
    endfunction

    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_CMP: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle
// controller; slave is the controller side, master the datapath side.
interface multicycle_controller_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] alu_flags;

    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;

    modport slave (
        input  op, funct, rd, cond, alu_flags,
        output ir_write, adr_src, alu_src_a, pc_write, reg_write, mem_write,
               alu_src_b, result_src, alu_control, imm_src, reg_src
    );

    modport master (
        output op, funct, rd, cond, alu_flags,
        input  ir_write, adr_src, alu_src_a, pc_write, reg_write, mem_write,
               alu_src_b, result_src, alu_control, imm_src, reg_src
    );
endinterface

// File: rtl/mc_cond_unit.sv
// Condition unit: NZ/CV flag registers, CondEx evaluation against the stored
// flags, and gating of the PC/register/memory write strobes.
module mc_cond_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [3:0] rd,
    input  logic       nz_req,
    input  logic       cv_req,
    input  logic       fetch_req,
    input  logic       br_req,
    input  logic       wb_req,
    input  logic       mem_req,
    output logic       cond_ex,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);

    logic [1:0] nz;
    logic [1:0] cv;
    logic       n, z, c, v;
    logic       rd_is_pc;

    assign {n, z} = nz;
    assign {c, v} = cv;
    assign rd_is_pc = (rd == PC_REG);

    // Flags update at the edge closing the execute cycle, so an instruction's
    // own condition always sees the pre-execute values.
    always_ff @(posedge clk) begin
        if (reset) begin
            nz <= 2'b00;
            cv <= 2'b00;
        end else begin
            if (nz_req && cond_ex) nz <= alu_flags[3:2];
            if (cv_req && cond_ex) cv <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pc_write  = !reset && (fetch_req || (br_req && cond_ex) ||
                                  (wb_req && rd_is_pc && cond_ex));
    assign reg_write = !reset && wb_req && !rd_is_pc && cond_ex;
    assign mem_write = !reset && mem_req && cond_ex;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: main FSM and instruction decode.
// Define MC_CTRL_STATE_OUT_EN to expose the current state on output port state.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  FETCH    | read instruction, PC <= PC + 4
//  DECODE   | read registers, compute PC + 8
//  MEMADR   | compute load/store address
//  MEMRD    | read data memory
//  MEMWB    | write loaded data to Rd (or PC)
//  MEMWR    | write data memory (conditional)
//  EXECR    | ALU op, register operand B
//  EXECI    | ALU op, immediate operand B
//  ALUWB    | write ALU result to Rd (or PC)
//  BRANCH   | PC <= PC + 8 + offset (conditional)
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
`ifdef MC_CTRL_STATE_OUT_EN
    ,
    output logic [3:0]              state
`endif
);

    state_t     cur_state, nxt_state;
    logic       i_bit, s_bit;
    logic [3:0] cmd;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control;
    logic       fetch_req, br_req, wb_req, mem_req, nz_req, cv_req;
    logic       cond_ex;

    assign i_bit = bus.funct[5];
    assign cmd   = bus.funct[4:1];
    assign s_bit = bus.funct[0];

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state   = cur_state;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        fetch_req   = 1'b0;
        br_req      = 1'b0;
        wb_req      = 1'b0;
        mem_req     = 1'b0;
        nz_req      = 1'b0;
        cv_req      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                fetch_req  = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_4;
                result_src = RES_ALU;
                nxt_state  = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_4;
                result_src = RES_ALU;
                case (bus.op)
                    OP_MEM:  nxt_state = S_MEMADR;
                    OP_DP:   nxt_state = i_bit ? S_EXECI : S_EXECR;
                    OP_BR:   nxt_state = S_BRANCH;
                    default: nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                nxt_state = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src   = 1'b1;
                nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                wb_req     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (cur_state == S_EXECI) ? SRCB_IMM : SRCB_REG;
                alu_control = cmd_alu(cmd);
                nz_req      = s_bit && cmd_supported(cmd);
                cv_req      = s_bit && cmd_arith(cmd);
                nxt_state   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                wb_req     = cmd_writes(cmd);
                nxt_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                br_req     = 1'b1;
                nxt_state  = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    mc_cond_unit #(.PC_REG(PC_REG)) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.cond),
        .alu_flags (bus.alu_flags),
        .rd        (bus.rd),
        .nz_req    (nz_req),
        .cv_req    (cv_req),
        .fetch_req (fetch_req),
        .br_req    (br_req),
        .wb_req    (wb_req),
        .mem_req   (mem_req),
        .cond_ex   (cond_ex),
        .pc_write  (bus.pc_write),
        .reg_write (bus.reg_write),
        .mem_write (bus.mem_write)
    );

    assign bus.ir_write    = fetch_req && !reset;
    assign bus.adr_src     = adr_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.result_src  = result_src;
    assign bus.alu_control = alu_control;
    assign bus.imm_src     = bus.op;
    assign bus.reg_src     = {bus.op == OP_MEM, bus.op == OP_BR};

`ifdef MC_CTRL_STATE_OUT_EN
    assign state = cur_state;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-instruction
// behavioural model of the control sequence and the NZCV flags.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

`ifdef MC_CTRL_STATE_OUT_EN
    logic [3:0] state_obs;
`endif

    multicycle_controller #(.PC_REG(4'd15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MC_CTRL_STATE_OUT_EN
        ,
        .state (state_obs)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // model state: stored flags
    logic fn_n = 1'b0, fn_z = 1'b0, fn_c = 1'b0, fn_v = 1'b0;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;

    function automatic logic model_cond(input logic [3:0] cc);
        case (cc)
            4'd0:  return fn_z;
            4'd1:  return !fn_z;
            4'd2:  return fn_c;
            4'd3:  return !fn_c;
            4'd4:  return fn_n;
            4'd5:  return !fn_n;
            4'd6:  return fn_v;
            4'd7:  return !fn_v;
            4'd8:  return fn_c && !fn_z;
            4'd9:  return !fn_c || fn_z;
            4'd10: return fn_n == fn_v;
            4'd11: return fn_n != fn_v;
            4'd12: return !fn_z && (fn_n == fn_v);
            4'd13: return fn_z || (fn_n != fn_v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_supported(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010 ||
               cmd == 4'b0000 || cmd == 4'b1100;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'd0;
            4'b0010: return 2'd1;
            4'b1010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // {ir, adr, srca, pcw, rw, mw, srcb[2], res[2], aluc[2], imm[2], regsrc[2]}
    function automatic logic [17:0] pack(input logic ir, adr, srca, pcw, rw, mw,
                                         input logic [1:0] srcb, res, aluc, imm, rsrc);
        return {ir, adr, srca, pcw, rw, mw, srcb, res, aluc, imm, rsrc};
    endfunction

    function automatic logic [17:0] observed();
        return pack(bus.ir_write, bus.adr_src, bus.alu_src_a, bus.pc_write, bus.reg_write,
                    bus.mem_write, bus.alu_src_b, bus.result_src, bus.alu_control,
                    bus.imm_src, bus.reg_src);
    endfunction

    function automatic logic [17:0] model_out(input int ph, input logic [1:0] op,
                                              input logic [5:0] fn, input logic [3:0] rd,
                                              input logic ce);
        logic ir = 0, adr = 0, srca = 0, pcw = 0, rw = 0, mw = 0;
        logic [1:0] srcb = 0, res = 0, aluc = 0;
        logic wb = 0;
        case (ph)
            P_FETCH:  begin ir = 1; srca = 1; srcb = 2; res = 2; pcw = 1; end
            P_DECODE: begin srca = 1; srcb = 2; res = 2; end
            P_MEMADR: srcb = 1;
            P_MEMRD:  adr = 1;
            P_MEMWR:  begin adr = 1; mw = ce; end
            P_MEMWB:  begin res = 1; wb = 1; end
            P_EXECR:  aluc = alu_of(fn[4:1]);
            P_EXECI:  begin srcb = 1; aluc = alu_of(fn[4:1]); end
            P_ALUWB:  wb = is_supported(fn[4:1]) && fn[4:1] != 4'b1010;
            P_BRANCH: begin srcb = 1; res = 2; pcw = ce; end
            default:  ;
        endcase
        if (wb) begin
            if (rd == 4'd15) pcw = ce;
            else             rw  = ce;
        end
        return pack(ir, adr, srca, pcw, rw, mw, srcb, res, aluc, op, {op == 2'b01, op == 2'b10});
    endfunction

    // Entry/exit invariant: just after a negedge, in the cycle that is (or will be) FETCH.
    // mid_reset_at: phase index at which reset is asserted instead of continuing (-1 = none).
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                             input logic [3:0] cc, input bit force_af, input logic [3:0] af,
                             input int mid_reset_at, input string name);
        int ph[$];
        logic ce;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (op)
            2'b00: begin ph.push_back(fn[5] ? P_EXECI : P_EXECR); ph.push_back(P_ALUWB); end
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (fn[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                else       ph.push_back(P_MEMWR);
            end
            2'b10: ph.push_back(P_BRANCH);
            default: ;
        endcase
        bus.op = op; bus.funct = fn; bus.rd = rd; bus.cond = cc;
        for (int k = 0; k < ph.size(); k++) begin
            bus.alu_flags = force_af ? af : 4'($urandom);
            if (k == mid_reset_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("%s_rst_writes", name),
                      {28'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 32'd0);
                fn_n = 0; fn_z = 0; fn_c = 0; fn_v = 0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            #1;
            ce = model_cond(cc);
            check($sformatf("%s_ph%0d", name, ph[k]), {14'd0, observed()},
                  {14'd0, model_out(ph[k], op, fn, rd, ce)});
            if ((ph[k] == P_EXECR || ph[k] == P_EXECI) && fn[0] && ce && is_supported(fn[4:1])) begin
                fn_n = bus.alu_flags[3];
                fn_z = bus.alu_flags[2];
                if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010 || fn[4:1] == 4'b1010) begin
                    fn_c = bus.alu_flags[1];
                    fn_v = bus.alu_flags[0];
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = 2'b00; bus.funct = 6'd0; bus.rd = 4'd0; bus.cond = 4'he; bus.alu_flags = 4'd0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_writes", {28'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 32'd0);
        end
        reset = 1'b0;

        // ADDS R1, AL, flags 0110 -> Z=1; then BEQ taken
        run_instr(2'b00, 6'b0_0100_1, 4'd1, 4'he, 1, 4'b0110, -1, "adds");
        check("adds_flags", {28'd0, fn_n, fn_z, fn_c, fn_v}, 32'b0110);
        run_instr(2'b10, 6'd0, 4'd0, 4'h0, 0, 4'd0, -1, "beq_taken");
        // CMP with 1001 -> NZ=10, CV=01; GE taken, NE taken
        run_instr(2'b00, 6'b0_1010_1, 4'd2, 4'he, 1, 4'b1001, -1, "cmp");
        check("cmp_flags", {28'd0, fn_n, fn_z, fn_c, fn_v}, 32'b1001);
        run_instr(2'b10, 6'd0, 4'd0, 4'ha, 0, 4'd0, -1, "bge");
        run_instr(2'b10, 6'd0, 4'd0, 4'h1, 0, 4'd0, -1, "bne_taken");
        // STR EQ with Z=0 -> no MemWrite
        run_instr(2'b01, 6'b1_1000_0, 4'd3, 4'h0, 0, 4'd0, -1, "str_eq");
        // ADDS with Z=1 then BNE not taken
        run_instr(2'b00, 6'b1_0100_1, 4'd4, 4'he, 1, 4'b0100, -1, "adds_z");
        run_instr(2'b10, 6'd0, 4'd0, 4'h1, 0, 4'd0, -1, "bne_not");
        // LDR into PC
        run_instr(2'b01, 6'b0_1100_1, 4'd15, 4'he, 0, 4'd0, -1, "ldr_pc");
        // reset in MEMRD (phase index 3), then BEQ must see cleared Z
        run_instr(2'b01, 6'b0_1100_1, 4'd5, 4'he, 0, 4'd0, 3, "ldr_rst");
        run_instr(2'b10, 6'd0, 4'd0, 4'h0, 0, 4'd0, -1, "beq_after_rst");
        // undefined op, unsupported cmd with S, conditional NV
        run_instr(2'b11, 6'b0_0100_1, 4'd1, 4'he, 0, 4'd0, -1, "undef");
        run_instr(2'b00, 6'b0_0111_1, 4'd6, 4'he, 1, 4'b1111, -1, "unsup");
        check("unsup_flags", {28'd0, fn_n, fn_z, fn_c, fn_v}, 32'd0);
        run_instr(2'b00, 6'b0_0100_0, 4'd7, 4'hf, 0, 4'd0, -1, "add_nv");

        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            logic [3:0] rd, cc, c4;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                c4 = 4'($urandom_range(0, 4));
                case (c4)
                    4'd0: fn[4:1] = 4'b0100;
                    4'd1: fn[4:1] = 4'b0010;
                    4'd2: fn[4:1] = 4'b1010;
                    4'd3: fn[4:1] = 4'b0000;
                    default: fn[4:1] = 4'b1100;
                endcase
            end
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cc = ($urandom_range(0, 3) == 0) ? 4'he : 4'($urandom);
            run_instr(op, fn, rd, cc, 0, 4'd0, -1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: PC_REG, 4'd15, register index treated as the program counter on writeback.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (memory).
REQ-006 Rd  input  4  destination register index.
REQ-007 Cond  input  4  condition field.
REQ-008 ALU_Flags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-009 Outputs, all 1 bit: IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite.
REQ-010 Outputs, all 2 bits: ALUSrcB (00 reg, 01 ExtImm, 10 const 4), ResultSrc (00 ALUOut, 01 Data, 10 ALU), ALUControl (00 ADD, 01 SUB, 10 AND, 11 ORR), ImmSrc (00 data-proc, 01 memory, 10 branch), RegSrc ([0] branch reads PC, [1] store reads Rd).

Function
REQ-011 Main FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-012 Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECI (Op=00, I=1), EXECR (Op=00, I=0), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMRD (L=1) or MEMWR (L=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-013 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1.
REQ-014 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10; no writes.
REQ-015 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. MEMRD: AdrSrc=1. MEMWR: AdrSrc=1, MemWrite=CondEx. MEMWB: ResultSrc=01, register write.
REQ-016 EXECR: ALUSrcB=00; EXECI: ALUSrcB=01; both ALUSrcA=0 with ALUControl from cmd: 0100->00, 0010->01, 1010 (CMP)->01, 0000->10, 1100->11.
REQ-017 ALUWB: ResultSrc=00, register write unless cmd=CMP or cmd unsupported.
REQ-018 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondEx.
REQ-019 Register write in MEMWB/ALUWB: if Rd==PC_REG then PCWrite=CondEx and RegWrite=0, else RegWrite=CondEx.
REQ-020 CondEx is combinational from Cond and stored flags: EQ..LE per ARM, 1110=1, 1111=0.
REQ-021 Flag registers NZ and CV; in EXECR/EXECI only, NZ loads when S=1 and CondEx=1; CV loads additionally only when cmd is ADD, SUB or CMP.
REQ-022 Flags loaded at the end of an execute cycle are visible to CondEx in the following cycle; an instruction's own condition uses pre-execute flags.
REQ-023 Unsupported cmd: ALUControl=00, no register or flag write, FSM sequence unchanged.
REQ-024 ImmSrc=Op and RegSrc={Op==01, Op==10} in all states.
REQ-025 All non-listed outputs are 0 in each state.

Reset
REQ-026 Reset=1 at a rising edge forces state FETCH and clears NZ and CV to 0, whatever the current state.
REQ-027 While Reset=1, PCWrite, RegWrite, MemWrite and IRWrite are 0.
REQ-028 The first FETCH occurs in the first cycle after Reset deasserts.

Configuration
REQ-029 Macro MC_CTRL_STATE_OUT_EN: when defined, adds output State (4 bits, state encoding from the package) reflecting the current state; when undefined, the port is absent and behaviour is otherwise identical.

Structure
REQ-030 Package mc_ctrl_pkg holds the state encodings, ALUControl/ResultSrc/ALUSrcB/ImmSrc encodings, cmd codes and condition codes.
REQ-031 Sub-module mc_cond_unit contains the flag registers, CondEx evaluation and write gating; the FSM and decode remain in the top module.

Verification
REQ-032 Reset mid-MEMRD -> next cycle FETCH, flags 0000, no writes while reset is asserted.
REQ-033 ADDS R1 with Cond=1110, ALU_Flags=0110 -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in ALUWB; the next EQ instruction sees Z=1.
REQ-034 LDR (Op=01, L=1) -> 5-cycle sequence; MEMWB ResultSrc=01; Rd=15 gives PCWrite=1 and RegWrite=0.
REQ-035 STR with Cond=0000 and Z=0 -> MEMWR MemWrite=0, return to FETCH.
REQ-036 Branch with Cond=0001 and Z=0 -> BRANCH PCWrite=1; with Z=1 -> PCWrite=0.
REQ-037 CMP with ALU_Flags=1001 -> no RegWrite; NZ=10 and CV=01 latched; then a GE instruction evaluates CondEx=1.
